// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// slave: the loader's view; master: the byte source / memory side.
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        we;
   logic [31:0] wa;
   logic [31:0] wd;

   modport master (
      output rx_data,
      output rx_valid,
      input  we,
      input  wa,
      input  wd
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output we,
      output wa,
      output wd
   );
endinterface

// File: rtl/imem_loader.sv
// Loads instruction memory from a framed byte stream: A5, 16-bit LE word count, LE words,
// XOR checksum. Define LOADER_TIMEOUT_EN to abort a load after TIMEOUT_CYCLES idle cycles.
module imem_loader #(
   parameter int unsigned ADDR_W         = 8,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [2:0] {
      StIdle, StSync, StLen0, StLen1, StData, StCsum, StDone, StErr
   } state_e;

   localparam int unsigned IdxW = ADDR_W + 1;
   // A 16-bit count can never exceed 2^16, so larger memories clamp the bound there.
   localparam int unsigned CapW = (ADDR_W > 16) ? 16 : ADDR_W;
   localparam logic [16:0] MaxLen = 17'(1) << CapW;

   if (BASE_ADDR[1:0] != 2'b00 || TIMEOUT_CYCLES == 0) begin : gen_param_check
      $error("imem_loader: BASE_ADDR must be word aligned and TIMEOUT_CYCLES nonzero");
   end

   state_e           state_q, state_d;
   logic [15:0]      len_q, len_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [IdxW-1:0]  word_idx_q, word_idx_d;
   logic [7:0]       csum_q, csum_d;
   logic [23:0]      asm_q, asm_d;
   logic             we_q, we_d;
   logic [31:0]      wa_q, wa_d;
   logic [31:0]      wd_q, wd_d;

   logic [15:0]      len_new;
   logic             bad_len;
   logic             last_word;
   logic             active;
   logic             timeout;

   assign active = (state_q == StSync) || (state_q == StLen0) || (state_q == StLen1) ||
                   (state_q == StData) || (state_q == StCsum);

   assign len_new   = {bus.rx_data, len_q[7:0]};
   assign bad_len   = (len_new == 16'd0) || ({1'b0, len_new} > MaxLen);
   assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned IdleW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [IdleW-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = '0;
      if (active && !bus.rx_valid) begin
         idle_d = idle_q + 1'b1;
      end
   end

   // The TIMEOUT_CYCLES-th consecutive idle cycle is the one that aborts.
   assign timeout = active && !bus.rx_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      asm_d      = asm_q;
      we_d       = 1'b0;
      wa_d       = wa_q;
      wd_d       = wd_q;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            // A byte arriving with start is dropped: the frame begins on the next byte.
            if (start) begin
               state_d    = StSync;
               len_d      = '0;
               byte_idx_d = '0;
               word_idx_d = '0;
               csum_d     = '0;
               asm_d      = '0;
            end
         end
         StSync: begin
            if (bus.rx_valid && bus.rx_data == 8'hA5) begin
               state_d = StLen0;
            end
         end
         StLen0: begin
            if (bus.rx_valid) begin
               len_d   = {8'h00, bus.rx_data};
               state_d = StLen1;
            end
         end
         StLen1: begin
            if (bus.rx_valid) begin
               len_d   = len_new;
               state_d = bad_len ? StErr : StData;
            end
         end
         StData: begin
            if (bus.rx_valid) begin
               csum_d     = csum_q ^ bus.rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  wa_d       = BASE_ADDR + 32'({word_idx_q, 2'b00});
                  wd_d       = {bus.rx_data, asm_q};
                  word_idx_d = word_idx_q + 1'b1;
                  if (last_word) begin
                     state_d = StCsum;
                  end
               end else begin
                  // Shift right so the first byte of the word ends up in bits [7:0].
                  asm_d = {bus.rx_data, asm_q[23:8]};
               end
            end
         end
         StCsum: begin
            if (bus.rx_valid) begin
               state_d = (bus.rx_data == csum_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase

      if (timeout) begin
         state_d = StErr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         len_q      <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         csum_q     <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         csum_q     <= csum_d;
         asm_q      <= asm_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
      end
   end

   assign bus.we = we_q;
   assign bus.wa = wa_q;
   assign bus.wd = wd_q;

   // ERR keeps the CPU held so a partially written program never runs.
   assign busy     = active;
   assign cpu_hold = active || (state_q == StErr);
   assign done     = (state_q == StDone);
   assign err      = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;
   localparam int unsigned ADDR_W         = 8;
   localparam logic [31:0] BASE_ADDR      = 32'h0000_0000;
   localparam int unsigned TIMEOUT_CYCLES = 100;
   localparam int StBusy = 0, StDone = 1, StErr = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic cpu_hold, busy, done, err;

   imem_loader_if bus ();

   imem_loader #(
      .ADDR_W         (ADDR_W),
      .BASE_ADDR      (BASE_ADDR),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] got_wa[$], got_wd[$], exp_wa[$], exp_wd[$];
   int exp_st;

   always @(negedge clk) begin
      if (bus.we) begin
         got_wa.push_back(bus.wa);
         got_wd.push_back(bus.wd);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expected writes and final status for a byte stream seen after start.
   task automatic model(input logic [7:0] s[$]);
      int i;
      int n;
      logic [7:0] cs;
      exp_wa.delete();
      exp_wd.delete();
      exp_st = StBusy;
      i = 0;
      while (i < s.size() && s[i] != 8'hA5) i++;
      if (i + 2 >= s.size()) return;
      n = int'(s[i+1]) + 256 * int'(s[i+2]);
      i += 3;
      if (n == 0 || n > (1 << ADDR_W)) begin
         exp_st = StErr;
         return;
      end
      cs = 8'h00;
      for (int w = 0; w < n; w++) begin
         if (i + 4 > s.size()) return;
         exp_wa.push_back(BASE_ADDR + 32'(4 * w));
         exp_wd.push_back({s[i+3], s[i+2], s[i+1], s[i]});
         cs ^= s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
         i += 4;
      end
      if (i >= s.size()) return;
      exp_st = (s[i] == cs) ? StDone : StErr;
   endtask

   task automatic mk_frame(input int n, input int noise, input bit bad, output logic [7:0] s[$]);
      logic [7:0] b;
      logic [7:0] cs;
      s = {};
      cs = 8'h00;
      for (int k = 0; k < noise; k++) begin
         b = 8'($urandom_range(0, 255));
         s.push_back((b == 8'hA5) ? 8'h5A : b);
      end
      s.push_back(8'hA5);
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int k = 0; k < 4 * n; k++) begin
         b = 8'($urandom_range(0, 255));
         cs ^= b;
         s.push_back(b);
      end
      if (bad) cs ^= 8'($urandom_range(1, 255));
      s.push_back(cs);
   endtask

   task automatic check_result(input string tag);
      int m;
      check({tag, ".nwr"}, 32'(got_wa.size()), 32'(exp_wa.size()));
      m = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
      for (int k = 0; k < m; k++) begin
         check($sformatf("%s.wa%0d", tag, k), got_wa[k], exp_wa[k]);
         check($sformatf("%s.wd%0d", tag, k), got_wd[k], exp_wd[k]);
      end
      check({tag, ".done"}, 32'(done), 32'(exp_st == StDone));
      check({tag, ".err"}, 32'(err), 32'(exp_st == StErr));
      check({tag, ".hold"}, 32'(cpu_hold), 32'(exp_st != StDone));
      check({tag, ".busy"}, 32'(busy), 32'(exp_st == StBusy));
   endtask

   task automatic run_frame(input string tag, input logic [7:0] s[$], input int gapmax);
      got_wa.delete();
      got_wd.delete();
      pulse_start();
      check({tag, ".busy_rise"}, 32'(busy), 32'd1);
      check({tag, ".hold_rise"}, 32'(cpu_hold), 32'd1);
      foreach (s[i]) send(s[i], $urandom_range(0, gapmax));
      model(s);
      check_result(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] s[$];
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;

      repeat (3) @(negedge clk);
      check("rst.we", 32'(bus.we), 32'd0);
      check("rst.wa", bus.wa, 32'd0);
      check("rst.wd", bus.wd, 32'd0);
      check("rst.hold", 32'(cpu_hold), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.err", 32'(err), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Nominal load with an extra start mid-frame that must be ignored.
      s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2, 8'h22};
      got_wa.delete();
      got_wd.delete();
      pulse_start();
      for (int i = 0; i < 3; i++) send(s[i], 0);
      pulse_start();
      for (int i = 3; i < s.size(); i++) send(s[i], $urandom_range(0, 1));
      model(s);
      check_result("nom");
      check("nom.wd0_fixed", got_wd[0], 32'hE3A00013);
      check("nom.wa1_fixed", got_wa[1], 32'h0000_0004);
      check("nom.wd1_fixed", got_wd[1], 32'hE2811001);

      // Bytes while DONE are ignored.
      send(8'hA5, 0);
      send(8'h01, 0);
      repeat (2) @(negedge clk);
      check("done_ign.done", 32'(done), 32'd1);
      check("done_ign.busy", 32'(busy), 32'd0);

      s = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3,
            8'h01, 8'h10, 8'h81, 8'hE2, 8'h22};
      run_frame("noise", s, 1);

      s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2, 8'h23};
      run_frame("badcs", s, 1);

      // start and a byte on the same edge: the byte is dropped.
      got_wa.delete();
      got_wd.delete();
      start = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      bus.rx_valid = 1'b0;
      mk_frame(1, 0, 1'b0, s);
      foreach (s[i]) send(s[i], 0);
      model(s);
      check_result("start_rx");

      s = '{8'hA5, 8'h00, 8'h00};
      run_frame("len0", s, 0);
      s = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame("len257", s, 0);
      mk_frame(256, 0, 1'b0, s);
      run_frame("len256", s, 0);
      check("len256.last_wa", got_wa[got_wa.size() - 1], 32'h0000_03FC);

      for (int r = 0; r < 10; r++) begin
         mk_frame($urandom_range(1, 6), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), s);
         run_frame($sformatf("rnd%0d", r), s, 2);
      end

      // Reset after the 6th data byte.
      got_wa.delete();
      got_wd.delete();
      pulse_start();
      mk_frame(2, 0, 1'b0, s);
      for (int i = 0; i < 9; i++) send(s[i], 0);
      check("mid.nwr_before", 32'(got_wa.size()), 32'd1);
      reset = 1'b0;
      #1;
      check("mid.we", 32'(bus.we), 32'd0);
      check("mid.wa", bus.wa, 32'd0);
      check("mid.wd", bus.wd, 32'd0);
      check("mid.hold", 32'(cpu_hold), 32'd0);
      check("mid.busy", 32'(busy), 32'd0);
      check("mid.done", 32'(done), 32'd0);
      check("mid.err", 32'(err), 32'd0);
      got_wa.delete();
      got_wd.delete();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 9; i < s.size(); i++) send(s[i], 0);
      repeat (3) @(negedge clk);
      check("mid.nwr_after", 32'(got_wa.size()), 32'd0);
      check("mid.idle_busy", 32'(busy), 32'd0);

`ifdef LOADER_TIMEOUT_EN
      got_wa.delete();
      got_wd.delete();
      pulse_start();
      mk_frame(2, 0, 1'b0, s);
      foreach (s[i]) send(s[i], (i == 2) ? int'(TIMEOUT_CYCLES) - 1 : 0);
      model(s);
      check_result("to99");

      pulse_start();
      send(8'hA5, 0);
      send(8'h02, 0);
      repeat (TIMEOUT_CYCLES) @(negedge clk);
      check("to100.err", 32'(err), 32'd1);
      check("to100.hold", 32'(cpu_hold), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the processor's instruction memory from a byte stream, such as a UART receiver's output, so a new program can be loaded without resynthesis. It sits between the byte source and the write port of a writable instruction memory. It parses a framed image (sync byte, word count, little-endian words, checksum) and issues one word write per received instruction. It holds the CPU in reset while loading.

## Interface
- ADDR_W, 8, word-address width of the target memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.
- TIMEOUT_CYCLES, 50_000, maximum number of idle cycles allowed between bytes. Used only with LOADER_TIMEOUT_EN.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that arms the loader.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid; the byte is consumed on this edge; one-cycle strobe per byte.
- we  output  1  memory write enable, one cycle per word.
- wa  output  32  byte write address; wa[1:0] always 2'b00; memory indexes with wa[31:2].
- wd  output  32  write data.
- cpu_hold  output  1  keeps the processor in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded and checksum correct.
- err  output  1  load failed.

## Operation
- States: IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE:
  - start moves to SYNC and sets cpu_hold=1 and busy=1.
  - start also clears done, err, the checksum, the byte index and the word index.
- SYNC:
  - A byte 8'hA5 moves to LEN0.
  - Any other byte is discarded and the state stays SYNC.
- LEN0 then LEN1 latch the word count N as 16 bits, low byte first.
- After LEN1:
  - N==0 or N>2^ADDR_W moves to ERR.
  - Otherwise the state moves to DATA.
- DATA:
  - Bytes assemble little-endian: the first byte goes to wd[7:0] and the fourth to wd[31:24].
  - On the fourth byte, one write is issued to wa = BASE_ADDR + 4*word_index and word_index increments.
  - After word N the state moves to CSUM.
- Checksum:
  - The checksum is the 8-bit XOR of every DATA byte.
  - The sync byte and length bytes are excluded.
- CSUM:
  - A received byte equal to the checksum moves to DONE; otherwise the state moves to ERR.
- DONE: cpu_hold=0, busy=0, done=1. The level holds until the next start.
- ERR: err=1, busy=0, and cpu_hold stays 1 so a corrupt program never runs. The level holds until the next start or reset.
- Words already written before an error are not rolled back.
- start while busy=1 is ignored.
- rx_valid in IDLE, DONE or ERR is ignored.
- A start and an rx_valid on the same edge in IDLE: start is taken and the byte is discarded.
- word_index is ADDR_W+1 bits wide, so no address wraps for valid N.

## Timing
- Reset values: state IDLE; we=0, wa=0, wd=0, cpu_hold=0, busy=0, done=0, err=0; all counters 0.
- Reset applied mid-load returns immediately to these values. No further writes occur and cpu_hold drops.
- Write timing:
  - we is registered. It is high for exactly the one cycle after the edge that accepted the fourth byte of a word.
  - wa and wd are stable during that cycle.
- Back-to-back rx_valid on consecutive cycles is supported at full rate of one byte per clock.
- done or err rises one cycle after the edge that accepts the checksum byte.
- err after a bad length rises one cycle after the edge that accepts LEN1.
- busy and cpu_hold rise one cycle after start.

## Configuration
- LOADER_TIMEOUT_EN
  - Defined: an idle counter runs in SYNC, LEN0, LEN1, DATA and CSUM. It resets on each accepted byte. Reaching TIMEOUT_CYCLES moves the state to ERR.
  - Undefined: no counter is built and the loader waits indefinitely. TIMEOUT_CYCLES is unused.

## Test plan
- Nominal load:
  - Stimulus: start, then A5 02 00, then 13 00 A0 E3, then 01 10 81 E2, then checksum.
  - Required: we twice, wa=0x0 with wd=E3A00013, and wa=0x4 with wd=E2811001.
  - Required: done=1, err=0, cpu_hold=0.
- Noise before sync: bytes 00 FF then a valid frame -> bytes before A5 are ignored and the load completes with done=1.
- Bad checksum: a nominal frame with checksum XOR 8'h01 -> both writes still happen, then err=1, cpu_hold=1, done=0.
- Length bounds:
  - N=0 -> err with no we.
  - N=257 with ADDR_W=8 -> err with no we.
  - N=256 -> the last write goes to wa=0x3FC.
- Mid-load reset: reset low after the 6th data byte -> all outputs are 0 at once, and no we follows after reset is released.
- Timeout, with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: stall 100 cycles after LEN0 -> err=1. A stall of 99 cycles -> the load continues normally.
